vred_andorxor_accum: RTL

//  Multi-beat accumulator for vredand/vredor/vredxor. Sits upstream of the
//  and/or/xor pair-reduction stage.

---
 rtl/vred_andorxor_accum.sv | 119 +++++++++++
 1 files changed

// File: rtl/vred_andorxor_accum.sv
// Multi-beat and/or/xor reduction accumulator.
// Each accepted beat is folded across its active lanes. The result is then folded into a
// running accumulator that is seeded with the scalar operand. After the last beat the
// result is held for the writeback stage until that stage accepts it.
module vred_andorxor_accum #(
    parameter int unsigned DATA_WIDTH  = 64,
    parameter int unsigned ELEM_WIDTH  = 32,
    parameter int unsigned OPSEL_WIDTH = 2,
    localparam int unsigned LANES      = DATA_WIDTH / ELEM_WIDTH
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic                   in_start,
    input  logic                   in_last,
    input  logic [OPSEL_WIDTH-1:0] in_opSel,
    input  logic [ELEM_WIDTH-1:0]  in_seed,
    input  logic [DATA_WIDTH-1:0]  in_data,
    input  logic [LANES-1:0]       in_mask,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [ELEM_WIDTH-1:0]  out_data
);

    localparam logic [OPSEL_WIDTH-1:0] OpAnd = OPSEL_WIDTH'(1);
    localparam logic [OPSEL_WIDTH-1:0] OpOr  = OPSEL_WIDTH'(2);
    localparam logic [OPSEL_WIDTH-1:0] OpXor = OPSEL_WIDTH'(3);

    typedef enum logic [1:0] {StIdle, StAcc, StHold} state_e;

    state_e                  state_q, state_d;
    logic [ELEM_WIDTH-1:0]   acc_q, acc_d;
    logic [OPSEL_WIDTH-1:0]  op_q, op_d;
    logic [ELEM_WIDTH-1:0]   out_data_q, out_data_d;
    logic [OPSEL_WIDTH-1:0]  beat_op;
    logic [ELEM_WIDTH-1:0]   beat_red;
    logic                    in_fire;

    // Two-operand fold; any op outside and/or/xor (including null) yields zero.
    function automatic logic [ELEM_WIDTH-1:0] fold(input logic [ELEM_WIDTH-1:0]  a,
                                                   input logic [ELEM_WIDTH-1:0]  b,
                                                   input logic [OPSEL_WIDTH-1:0] op);
        logic [ELEM_WIDTH-1:0] r;
        r = '0;
        if (op == OpAnd)      r = a & b;
        else if (op == OpOr)  r = a | b;
        else if (op == OpXor) r = a ^ b;
        return r;
    endfunction

    function automatic logic [ELEM_WIDTH-1:0] identity(input logic [OPSEL_WIDTH-1:0] op);
        return (op == OpAnd) ? '1 : '0;
    endfunction

    assign in_ready  = (state_q != StHold) & ~rst;
    assign in_fire   = in_valid & in_ready;
    assign out_valid = (state_q == StHold);
    assign out_data  = out_data_q;

    // A start beat is reduced with its own op, not the one latched from a previous reduction.
    assign beat_op = in_start ? in_opSel : op_q;

    // Fold the lanes of the current beat; masked lanes contribute the op identity.
    always_comb begin
        logic [ELEM_WIDTH-1:0] lane;
        lane     = '0;
        beat_red = identity(beat_op);
        for (int unsigned i = 0; i < LANES; i++) begin
            lane     = in_mask[i] ? in_data[i*ELEM_WIDTH +: ELEM_WIDTH] : identity(beat_op);
            beat_red = fold(beat_red, lane, beat_op);
        end
    end

    // Next-state, accumulator and result capture.
    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        op_d       = op_q;
        out_data_d = out_data_q;
        unique case (state_q)
            StIdle, StAcc: begin
                if (in_fire) begin
                    if (in_start) begin
                        // Start beats always (re)open a reduction, abandoning any in flight.
                        op_d    = in_opSel;
                        acc_d   = fold(in_seed, beat_red, in_opSel);
                        state_d = in_last ? StHold : StAcc;
                    end else if (state_q == StAcc) begin
                        acc_d = fold(acc_q, beat_red, op_q);
                        if (in_last) state_d = StHold;
                    end
                end
            end
            StHold: begin
                if (out_ready) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        // Capture the result separately so out_data survives the next reduction's start.
        if (state_q != StHold && state_d == StHold) out_data_d = acc_d;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= StIdle;
            acc_q      <= '0;
            op_q       <= '0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            op_q       <= op_d;
            out_data_q <= out_data_d;
        end
    end

endmodule
